// File: rtl/division_seq.sv
// Multi-cycle radix-2 restoring divider for the CPU ALU.
// Produces one quotient bit per cycle from magnitudes, then fixes up signs.
// Divide-by-zero and signed overflow skip the iteration and finish
// immediately. Flags follow the ALU ordering {N, Z, C, V}.
module division_seq #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] c,
    output logic [n-1:0] r,
    output logic [3:0]   banderas
);

    localparam int CW = $clog2(n);
    localparam logic [CW-1:0] LAST_COUNT = CW'(n - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [n-1:0]  MOST_NEG   = {1'b1, {(n-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [n:0]    rem_q, rem_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic          neg_quo_q, neg_quo_d;
    logic          neg_rem_q, neg_rem_d;
    logic          sgn_q, sgn_d;
    logic [n-1:0]  c_q, c_d;
    logic [n-1:0]  r_q, r_d;
    logic [3:0]    flags_q, flags_d;

    logic          a_neg, b_neg;
    logic [n-1:0]  abs_a, abs_b;
    logic          div_zero, ovf;

    logic          fits;
    logic [n-1:0]  rem_after;
    logic [n-1:0]  quo_step;
    logic [n-1:0]  quo_final;
    logic [n-1:0]  rem_final;

    // Flag vector for a finished result: N only means something in signed mode,
    // C is always clear for division.
    function automatic logic [3:0] make_flags(input logic [n-1:0] q,
                                              input logic         s,
                                              input logic         v);
        return {s & q[n-1], q == '0, 1'b0, v};
    endfunction

    // Operand preparation at capture: magnitudes and the two special cases.
    always_comb begin
        a_neg    = signed_op & a[n-1];
        b_neg    = signed_op & b[n-1];
        abs_a    = a_neg ? -a : a;
        abs_b    = b_neg ? -b : b;
        div_zero = (b == '0);
        ovf      = signed_op & (a == MOST_NEG) & (b == '1);
    end

    // One restoring step: the partial remainder is compared against the
    // divisor; the difference always fits in n bits when it is kept.
    always_comb begin
        fits      = (rem_q >= {1'b0, dvs_q});
        rem_after = fits ? (rem_q[n-1:0] - dvs_q) : rem_q[n-1:0];
        quo_step  = {quo_q[n-2:0], fits};
        quo_final = neg_quo_q ? -quo_step : quo_step;
        rem_final = neg_rem_q ? -rem_after : rem_after;
    end

    // Next-state logic: capture, iterate, publish results on completion.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sgn_d     = sgn_q;
        c_d       = c_q;
        r_d       = r_q;
        flags_d   = flags_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    sgn_d = signed_op;
                    if (div_zero) begin
                        c_d     = '1;
                        r_d     = a;
                        flags_d = make_flags('1, signed_op, 1'b1);
                        state_d = DONE;
                    end else if (ovf) begin
                        c_d     = a;
                        r_d     = '0;
                        flags_d = make_flags(a, 1'b1, 1'b1);
                        state_d = DONE;
                    end else begin
                        // Dividend MSB enters the remainder first; the rest
                        // shifts out of the quotient register one bit a cycle.
                        rem_d     = {{n{1'b0}}, abs_a[n-1]};
                        quo_d     = {abs_a[n-2:0], 1'b0};
                        dvs_d     = abs_b;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        count_d   = '0;
                        state_d   = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d   = {rem_after, quo_q[n-1]};
                quo_d   = quo_step;
                count_d = count_q + COUNT_ONE;
                if (count_q == LAST_COUNT) begin
                    c_d     = quo_final;
                    r_d     = rem_final;
                    flags_d = make_flags(quo_final, sgn_q, 1'b0);
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; a reset abandons
    // any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sgn_q     <= 1'b0;
            c_q       <= '0;
            r_q       <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sgn_q     <= sgn_d;
            c_q       <= c_d;
            r_q       <= r_d;
            flags_q   <= flags_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign c        = c_q;
    assign r        = r_q;
    assign banderas = flags_q;

endmodule

// File: tb/tb_division_seq.sv
// Scoreboard bench for division_seq at n=8: stimulus pushes hand-computed
// results, a monitor pops and compares whenever done pulses.
module tb_division_seq;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] c;
    logic [N-1:0] r;
    logic [3:0]   banderas;

    typedef struct {
        string        name;
        logic [N-1:0] c;
        logic [N-1:0] r;
        logic [3:0]   f;
        int           doneCyc;
        int           busyCyc;
    } exp_t;

    exp_t sb[$];

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    int busyCount  = 0;
    int doneCount  = 0;

    division_seq #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .c         (c),
        .r         (r),
        .banderas  (banderas)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time done relative to the start request
    always @(posedge clk) cyc <= cyc + 1;

    // Generic comparison with failure reporting
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Present one request for a cycle and record its expected outcome;
    // special cases finish one cycle after the request, others after N+1.
    task automatic applyStimulus(input string name, input logic sgn,
                                 input logic [N-1:0] av, input logic [N-1:0] bv,
                                 input logic [N-1:0] ec, input logic [N-1:0] er,
                                 input logic [3:0] ef, input logic special,
                                 input logic waitEdge);
        exp_t e;
        if (waitEdge) @(negedge clk);
        signed_op = sgn;
        a         = av;
        b         = bv;
        start     = 1'b1;
        e.name    = name;
        e.c       = ec;
        e.r       = er;
        e.f       = ef;
        e.doneCyc = cyc + (special ? 1 : N + 1);
        e.busyCyc = special ? 0 : N;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic waitDone(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checkOutput({name, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_c"}, 32'(c), 32'(e.c));
                checkOutput({e.name, "_r"}, 32'(r), 32'(e.r));
                checkOutput({e.name, "_flags"}, 32'(banderas), 32'(e.f));
                checkOutput({e.name, "_done_cycle"}, 32'(cyc), 32'(e.doneCyc));
                checkOutput({e.name, "_busy_cycles"}, 32'(busyCount), 32'(e.busyCyc));
                checkOutput({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
            end
            busyCount = 0;
        end else if (busy) begin
            busyCount++;
        end else begin
            busyCount = 0;
        end
    end

    // Directed sequence
    initial begin
        int dc;
        rst       = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_c", 32'(c), 32'd0);
        checkOutput("reset_r", 32'(r), 32'd0);
        checkOutput("reset_flags", 32'(banderas), 32'd0);
        rst = 1'b0;

        applyStimulus("u_100_7", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 4'b0000, 1'b0, 1'b1);
        waitDone("u_100_7");
        applyStimulus("s_m7_2", 1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 4'b1000, 1'b0, 1'b1);
        waitDone("s_m7_2");
        applyStimulus("s_7_m2", 1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 4'b1000, 1'b0, 1'b1);
        waitDone("s_7_m2");
        applyStimulus("s_m7_m2", 1'b1, 8'hF9, 8'hFE, 8'h03, 8'hFF, 4'b0000, 1'b0, 1'b1);
        waitDone("s_m7_m2");
        applyStimulus("s_div0", 1'b1, 8'h55, 8'h00, 8'hFF, 8'h55, 4'b1001, 1'b1, 1'b1);
        waitDone("s_div0");
        applyStimulus("u_div0", 1'b0, 8'h55, 8'h00, 8'hFF, 8'h55, 4'b0001, 1'b1, 1'b1);
        waitDone("u_div0");
        applyStimulus("s_ovf", 1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 4'b1001, 1'b1, 1'b1);
        waitDone("s_ovf");
        applyStimulus("u_80_ff", 1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 4'b0100, 1'b0, 1'b1);
        waitDone("u_80_ff");
        applyStimulus("s_m128_1", 1'b1, 8'h80, 8'h01, 8'h80, 8'h00, 4'b1000, 1'b0, 1'b1);
        waitDone("s_m128_1");
        applyStimulus("s_m128_m128", 1'b1, 8'h80, 8'h80, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b1);
        waitDone("s_m128_m128");
        applyStimulus("u_5_10", 1'b0, 8'd5, 8'd10, 8'd0, 8'd5, 4'b0100, 1'b0, 1'b1);
        waitDone("u_5_10");

        // Start pulse during RUN is ignored; a request in the DONE cycle is
        // taken at once.
        applyStimulus("u_200_3", 1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 4'b0000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        signed_op = 1'b1;
        a         = 8'd9;
        b         = 8'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("b2b_in_done_cycle", 32'(done), 32'd1);
        applyStimulus("b2b_s_m100_7", 1'b1, 8'h9C, 8'd7, 8'hF2, 8'hFE, 4'b1000, 1'b0, 1'b0);
        waitDone("b2b");

        applyStimulus("u_255_1", 1'b0, 8'd255, 8'd1, 8'hFF, 8'h00, 4'b0000, 1'b0, 1'b1);
        waitDone("u_255_1");

        // Reset mid-operation: results clear and the aborted op never completes
        applyStimulus("u_250_3_aborted", 1'b0, 8'd250, 8'd3, 8'd83, 8'd1, 4'b0000, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_c", 32'(c), 32'd0);
        checkOutput("midreset_r", 32'(r), 32'd0);
        checkOutput("midreset_flags", 32'(banderas), 32'd0);
        rst = 1'b0;
        dc  = doneCount;
        repeat (12) @(posedge clk);
        checkOutput("midreset_no_done", 32'(doneCount), 32'(dc));

        applyStimulus("u_0_5", 1'b0, 8'd0, 8'd5, 8'd0, 8'd0, 4'b0100, 1'b0, 1'b1);
        waitDone("u_0_5");

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/division_seq.md
Name: division_seq

Overview:
- Multi-cycle iterative divider for the CPU ALU. It is the parametrised successor of the combinational divider.
- Adds remainder output, signed/unsigned mode, a start/busy/done handshake, and defined divide-by-zero and overflow handling.
- Flag vector keeps the ALU ordering {N, Z, C, V} so the flag-select logic consumes it unchanged.
- Radix-2 restoring algorithm, one quotient bit per cycle. Frees the critical path of the single-cycle "/" operator.

Parameters:
- n, 32, operand/result width in bits (min 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE or DONE
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a  in  n  dividend; captured with start
- b  in  n  divisor; captured with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when results become valid
- c  out  n  quotient
- r  out  n  remainder
- banderas  out  4  [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Reset: clk and rst only; synchronous, active-high. State→IDLE. busy=0, done=0, c=0, r=0, banderas=0. Applies mid-operation: the operation is abandoned with no done pulse.
- States:
  - IDLE.
  - RUN: n iterations.
  - DONE: done=1 for exactly one cycle.
  - Transitions:
    - IDLE/DONE + start → RUN, or DONE directly for special cases.
    - RUN with count==n-1 → DONE.
    - DONE without start → IDLE.
- Capture: at the edge where start=1 in IDLE/DONE, latch a, b, signed_op. busy=1 from the next cycle.
- start while busy=1 is ignored. No queueing, and in-flight operands are unaffected.
- Latency, normal case: start at edge k. RUN occupies cycles k+1..k+n. done=1 and busy=0 in cycle k+n+1.
- Back-to-back: start asserted during the DONE cycle begins a new operation immediately, giving a throughput of one op per n+1 cycles.
- Signed pre/post-processing:
  - Operate on absolute values.
  - Quotient negated if sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - Rounding is truncation toward zero: a = c*b + r, |r|<|b|.
- Unsigned: plain magnitude division. Operands are never sign-extended.
- Divide by zero (b==0), detected at capture, skips RUN and enters DONE at edge k+1 (done in cycle k+1):
  - c = all ones (unsigned 2^n-1; signed −1).
  - r = a.
  - V = 1.
- Signed overflow (signed_op=1, a=most-negative, b=−1) also skips RUN and enters DONE at edge k+1:
  - c = a (most-negative).
  - r = 0.
  - V = 1.
- Flags, registered and updated together with c/r:
  - N = c[n-1] if signed_op, else 0.
  - Z = (c==0).
  - C = 0.
  - V = 1 only in the two special cases above.
- c, r and banderas hold their values after done until the next completion or reset. While busy they keep the previous result; no intermediate values are exposed.
- Internal widths: partial-remainder register n+1 bits, iteration counter ceil(log2 n) bits. No arithmetic wraps except the defined negations.

Test Plan:
- n=8, unsigned, a=100, b=7, start 1 cycle → done exactly 9 cycles after the start edge; c=14, r=2, banderas=4'b0000; busy high for 8 cycles.
- n=8, signed, a=0xF9 (−7), b=0x02 → c=0xFD (−3), r=0xFF (−1), banderas=4'b1000. Repeat with a=7, b=−2: c=0xFD, r=0x01.
- n=8, a=0x55, b=0, signed and unsigned → done 1 cycle after start; c=0xFF, r=0x55, V=1; N=1 in signed mode only.
- n=8, signed, a=0x80, b=0xFF → done after 1 cycle; c=0x80, r=0, banderas=4'b1001. Same operands unsigned → c=0, r=0x80, banderas=4'b0100 after 9 cycles.
- Start a=200, b=3 (unsigned). Pulse start with a=9, b=3 in RUN cycle 3 → ignored; result c=66, r=2. Then assert start in the DONE cycle → next op begins, no idle gap.
- Assert rst in RUN cycle 4 → next cycle busy=0, c=0, r=0, banderas=0, no done pulse. A new op after reset completes correctly (0/5 → c=0, r=0, Z=1).
